// File: rtl/sar_spi_readout.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : sar_spi_readout
// Brief    : Buffers sar_control conversion results in a small FIFO and lets
//            an off-chip host drain them through an SPI mode-0 responder.
//            All SPI pins are oversampled in the clk domain.
// Revision : 1.0 - initial release
// ============================================================================
module sar_spi_readout #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        result,
  input  logic                     valid,
  input  logic                     spi_csn_n,
  input  logic                     spi_sclk,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overrun
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_shift = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  // --------------------------------------------------------------------------
  // Pin synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic                   csn_prev_q, csn_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   csn_s, sclk_s;
  logic                   csn_fall, csn_rise, sclk_rise, sclk_fall;

  generate
    if (SYNC_STAGES > 1) begin : g_sync_chain
      // Shift each pin through the synchronizer chain
      always_comb begin
        csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_csn_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      end
    end else begin : g_sync_single
      // Single-flop capture of each pin
      always_comb begin
        csn_sync_d  = spi_csn_n;
        sclk_sync_d = spi_sclk;
      end
    end
  endgenerate

  assign csn_s       = csn_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign csn_prev_d  = csn_s;
  assign sclk_prev_d = sclk_s;
  assign csn_fall    = csn_prev_q & ~csn_s;
  assign csn_rise    = ~csn_prev_q & csn_s;
  assign sclk_rise   = ~sclk_prev_q & sclk_s;
  assign sclk_fall   = sclk_prev_q & ~sclk_s;

  // Synchronizer flops; CS_N idles high, SCLK idles low (mode 0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csn_sync_q  <= '1;
      sclk_sync_q <= '0;
      csn_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      csn_sync_q  <= csn_sync_d;
      sclk_sync_q <= sclk_sync_d;
      csn_prev_q  <= csn_prev_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_lvl_w-1:0] level_q, level_d;
  logic               overrun_q, overrun_d;
  logic               fifo_full, fifo_empty;
  logic               push, pop, drop;
  logic               commit_q, commit_d;
  logic               snap_empty_q, snap_empty_d;
  logic               snap_ovr_q, snap_ovr_d;
  logic [DATA_W-1:0]  head_word;
  logic [7:0]         head_byte;
  logic [2:0]         level_sat;

  assign fifo_full  = (level_q == c_lvl_w'(DEPTH));
  assign fifo_empty = (level_q == '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign pop        = commit_q & ~snap_empty_q;
  assign push       = valid & (~fifo_full | pop);
  assign drop       = valid & fifo_full & ~pop;
  assign head_word  = mem_q[rd_ptr_q];
  assign level_sat  = (level_q > c_lvl_w'(7)) ? 3'd7 : 3'(level_q);

  generate
    if (DATA_W >= 8) begin : g_head_trunc
      assign head_byte = head_word[DATA_W-1 -: 8];
    end else begin : g_head_pad
      assign head_byte = {head_word, {(8-DATA_W){1'b0}}};
    end
  endgenerate

  // Next-state for storage, pointers, level and the sticky overrun flag
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = result;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (commit_q && snap_ovr_q) begin
      overrun_d = 1'b0;
    end
  end

  // FIFO state registers; contents are discarded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // SPI responder FSM
  // --------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic        oe_q, oe_d;

  // Frame sequencing: snapshot at LOAD, shift on SCLK falls, commit once at DONE
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    oe_d         = oe_q;
    commit_d     = 1'b0;
    snap_empty_d = snap_empty_q;
    snap_ovr_d   = snap_ovr_q;
    case (state_q)
      c_st_idle: begin
        oe_d    = 1'b0;
        shift_d = '0;
        if (csn_fall) begin
          state_d = c_st_load;
        end
      end
      c_st_load: begin
        if (csn_rise) begin
          state_d = c_st_idle;
        end else begin
          shift_d      = {fifo_empty, overrun_q, 3'b000, level_sat,
                          fifo_empty ? 8'h00 : head_byte};
          snap_empty_d = fifo_empty;
          snap_ovr_d   = overrun_q;
          oe_d         = 1'b1;
          bitcnt_d     = '0;
          state_d      = c_st_shift;
        end
      end
      c_st_shift: begin
        if (csn_rise) begin
          // Aborted frame: nothing is popped and overrun is left as is
          state_d = c_st_idle;
          oe_d    = 1'b0;
          shift_d = '0;
        end else begin
          if (sclk_rise) begin
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == 5'd15) begin
              state_d  = c_st_done;
              commit_d = 1'b1;
            end
          end
          if (sclk_fall && (bitcnt_q < 5'd16)) begin
            shift_d = {shift_q[14:0], 1'b0};
          end
        end
      end
      default: begin  // c_st_done
        if (sclk_fall) begin
          shift_d = {shift_q[14:0], 1'b0};
        end
        // Level test so a CS_N rise racing the last SCLK is never missed
        if (csn_s) begin
          state_d = c_st_idle;
          oe_d    = 1'b0;
          shift_d = '0;
        end
      end
    endcase
  end

  // FSM and shift-register flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= c_st_idle;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      oe_q         <= 1'b0;
      commit_q     <= 1'b0;
      snap_empty_q <= 1'b0;
      snap_ovr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      oe_q         <= oe_d;
      commit_q     <= commit_d;
      snap_empty_q <= snap_empty_d;
      snap_ovr_q   <= snap_ovr_d;
    end
  end

  assign spi_miso    = oe_q & shift_q[15];
  assign spi_miso_oe = oe_q;
  assign fifo_level  = level_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sar_spi_readout.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_sar_spi_readout
// Brief    : Directed self-checking bench for sar_spi_readout (DATA_W=8,
//            DEPTH=4). Acts as SPI host with SCLK = clk/16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_spi_readout;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] result = 8'h00;
  logic       valid = 1'b0;
  logic       spi_csn_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [2:0] fifo_level;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  sar_spi_readout #(
    .DATA_W      (8),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .result      (result),
    .valid       (valid),
    .spi_csn_n   (spi_csn_n),
    .spi_sclk    (spi_sclk),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .fifo_level  (fifo_level),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] v);
    @(negedge clk);
    result = v;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  // Host read of nbits; optional valid pulse aligned with the commit cycle
  task automatic spi_read(input int nbits, input bit inject, input logic [7:0] inj_val,
                          output logic [15:0] data);
    data = '0;
    @(negedge clk);
    spi_csn_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b1;
      data     = {data[14:0], spi_miso};
      if (inject && (i == nbits - 1)) begin
        wait_clk(3);
        result = inj_val;
        valid  = 1'b1;
        wait_clk(1);
        valid  = 1'b0;
        wait_clk(4);
      end else begin
        wait_clk(8);
      end
      spi_sclk = 1'b0;
      wait_clk(8);
    end
    spi_csn_n = 1'b1;
    wait_clk(8);
  endtask

  logic [15:0] rd;

  initial begin
    // Reset state
    wait_clk(3);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // T2 single entry
    push(8'hA5);
    check("t2_level_after_push", {29'd0, fifo_level}, 32'd1);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t2_frame", {16'd0, rd}, 32'h01A5);
    check("t2_level_after_read", {29'd0, fifo_level}, 32'd0);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t2_empty_frame", {16'd0, rd}, 32'h8000);
    check("t2_level_empty", {29'd0, fifo_level}, 32'd0);

    // T3 overrun
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    check("t3_overrun_set", {31'd0, overrun}, 32'd1);
    check("t3_level_full", {29'd0, fifo_level}, 32'd4);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t3_frame0", {16'd0, rd}, 32'h4411);
    check("t3_overrun_cleared", {31'd0, overrun}, 32'd0);
    check("t3_level3", {29'd0, fifo_level}, 32'd3);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t3_frame1", {16'd0, rd}, 32'h0322);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t3_frame2", {16'd0, rd}, 32'h0233);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t3_frame3", {16'd0, rd}, 32'h0144);
    check("t3_level_drained", {29'd0, fifo_level}, 32'd0);

    // T4 abort after 9 SCLKs
    push(8'h3C); push(8'h7E);
    spi_read(9, 1'b0, 8'h00, rd);
    check("t4_partial_bits", {16'd0, rd}, 32'h0004);
    check("t4_level_kept", {29'd0, fifo_level}, 32'd2);
    check("t4_overrun", {31'd0, overrun}, 32'd0);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t4_frame0", {16'd0, rd}, 32'h023C);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t4_frame1", {16'd0, rd}, 32'h017E);

    // T5 push coinciding with the commit of a full FIFO
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    check("t5_level_full", {29'd0, fifo_level}, 32'd4);
    spi_read(16, 1'b1, 8'h99, rd);
    check("t5_frame0", {16'd0, rd}, 32'h0401);
    check("t5_level_stays", {29'd0, fifo_level}, 32'd4);
    check("t5_overrun_stays", {31'd0, overrun}, 32'd0);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t5_frame1", {16'd0, rd}, 32'h0402);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t5_frame2", {16'd0, rd}, 32'h0303);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t5_frame3", {16'd0, rd}, 32'h0204);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t5_tail", {16'd0, rd}, 32'h0199);

    // T6 pointer wrap with alternating push/read
    for (int i = 0; i < 10; i++) begin
      push(8'(i));
      check("t6_level_one", {29'd0, fifo_level}, 32'd1);
      spi_read(16, 1'b0, 8'h00, rd);
      check("t6_frame", {16'd0, rd}, 32'h0100 | i);
      check("t6_level_zero", {29'd0, fifo_level}, 32'd0);
    end

    // T1 asynchronous reset mid-frame
    push(8'h80); push(8'h81); push(8'h82); push(8'h83); push(8'h84);
    check("t1_pre_overrun", {31'd0, overrun}, 32'd1);
    @(negedge clk);
    spi_csn_n = 1'b0;
    wait_clk(8);
    spi_sclk = 1'b1;
    wait_clk(8);
    spi_sclk = 1'b0;
    wait_clk(8);
    check("t1_pre_oe", {31'd0, spi_miso_oe}, 32'd1);
    check("t1_pre_miso", {31'd0, spi_miso}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_miso", {31'd0, spi_miso}, 32'd0);
    check("t1_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("t1_level", {29'd0, fifo_level}, 32'd0);
    check("t1_overrun", {31'd0, overrun}, 32'd0);
    spi_csn_n = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    spi_read(16, 1'b0, 8'h00, rd);
    check("t1_post_frame", {16'd0, rd}, 32'h8000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
